muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Sequences the multi-cycle Mult and Div units on behalf of the main control FSM.
- Accepts a one-cycle start request and drives the unit's run control for a fixed cycle count.
- Commits the selected result into the Hi/Lo registers by driving the Hi/Lo source select and the Hi/Lo write pulse.
- Detects divide-by-zero at launch and reports it to control instead of running Div.

Parameters:
MULT_CYCLES, 32, number of cycles mult_ctrl is held high for one multiplication (>=1)
DIV_CYCLES, 32, number of cycles div_ctrl is held high for one division (>=1)
CNT_W, 6, width of the cycle counter; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request from control; sampled only in IDLE
op  input  1  operation, sampled with start: 0 = mult, 1 = div
div_zero  input  1  Div unit divisor-is-zero flag, sampled with start when op=1
mult_ctrl  output  1  run/enable to Mult unit (MultControl)
div_ctrl  output  1  run/enable to Div unit (DivControl)
src_hilo  output  1  Hi/Lo source select: 0 = Mult outputs, 1 = Div outputs (SrcHiLo)
hilo_write  output  1  Hi/Lo register write enable (HiLoWrite), one-cycle pulse
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on successful commit
div_zero_exc  output  1  one-cycle pulse when a division is refused
cycle_cnt  output  CNT_W  remaining run cycles (debug/visibility)

Behaviour:
- States: IDLE, RUN_MULT, RUN_DIV, COMMIT, EXC. State register and all outputs are registered.
- Reset (synchronous, at a rising edge with reset=1): state=IDLE; all 1-bit outputs 0; cycle_cnt=0. Reset overrides every other input, including in mid-operation. An aborted operation never produces hilo_write.
- IDLE:
  - start=1, op=0 -> RUN_MULT; cycle_cnt loads MULT_CYCLES-1; src_hilo latches 0.
  - start=1, op=1, div_zero=0 -> RUN_DIV; cycle_cnt loads DIV_CYCLES-1; src_hilo latches 1.
  - start=1, op=1, div_zero=1 -> EXC; src_hilo latches 1.
  - start=0 -> stay in IDLE.
- RUN_MULT / RUN_DIV:
  - mult_ctrl (resp. div_ctrl) is 1 for every cycle in the state.
  - cycle_cnt decrements by 1 per cycle.
  - When cycle_cnt==0 the next state is COMMIT.
  - Run length is exactly MULT_CYCLES (resp. DIV_CYCLES) cycles.
- COMMIT: one cycle; hilo_write=1, done=1, run controls 0; next state IDLE.
- EXC: one cycle; div_zero_exc=1, hilo_write=0, done=0, div_ctrl never asserted; next state IDLE.
- src_hilo holds its last latched value in all states, including IDLE, so Hi/Lo input muxing stays stable.
- start while busy=1 is ignored, with no queuing. This includes start asserted in the COMMIT or EXC cycle.
- Timing for mult, with start sampled at edge E0:
  - cycles 1..N: RUN_MULT, with cycle_cnt N-1..0.
  - cycle N+1: COMMIT.
  - cycle N+2: IDLE, earliest next accept.
- Total latency from start to the done pulse is N+1 cycles.
- cycle_cnt is 0 in IDLE, COMMIT and EXC.
- At most one of mult_ctrl, div_ctrl, hilo_write, div_zero_exc is high in any cycle.

Optional Feature:
- Macro MULDIV_ABORT_EN.
- When defined: adds input port abort (1 bit). abort=1 in RUN_MULT or RUN_DIV -> IDLE at the next edge; run controls drop; no hilo_write, no done; cycle_cnt=0. abort has no effect in other states. reset still has priority over abort.
- When undefined: port absent; runs always complete.

Test Plan:
1. Reset, then start=1, op=0 for one cycle (MULT_CYCLES=32) -> mult_ctrl high for exactly 32 cycles; hilo_write=1, done=1, src_hilo=0 in cycle 33; busy low from cycle 34.
2. Start op=1, div_zero=0 (DIV_CYCLES=32) -> div_ctrl high for 32 cycles; cycle_cnt counts 31..0; commit pulse with src_hilo=1; mult_ctrl never high.
3. Start op=1, div_zero=1 -> div_zero_exc=1 for one cycle at cycle 1; div_ctrl, hilo_write and done stay 0; IDLE at cycle 2.
4. Start held high continuously, op=0 -> accepts every 34 cycles; the start in the COMMIT cycle is ignored; no overlapping runs.
5. Reset asserted at cycle 10 of a mult -> IDLE and all outputs 0 after that edge; no hilo_write ever; a new start is accepted the cycle after reset deasserts.
6. With MULDIV_ABORT_EN: abort at cycle 5 of a div -> IDLE next cycle, div_ctrl=0, no done or hilo_write; a subsequent mult completes normally.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Sequences the multi-cycle Mult and Div units for the main control FSM.
//   A one-cycle start launches a run of fixed length; on completion the
//   selected result is committed to Hi/Lo with a one-cycle write pulse.
//   A division with a zero divisor is refused at launch and reported
//   through div_zero_exc instead of running Div.
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - synchronous, active-high reset
//   start        - launch request, sampled only in IDLE
//   op           - 0 = mult, 1 = div (sampled with start)
//   div_zero     - divisor-is-zero flag (sampled with start when op=1)
//   abort        - (MULDIV_ABORT_EN only) cancel a running operation
//   mult_ctrl    - Mult unit run enable
//   div_ctrl     - Div unit run enable
//   src_hilo     - Hi/Lo source select: 0 = Mult, 1 = Div (held between ops)
//   hilo_write   - Hi/Lo write enable, one-cycle pulse in COMMIT
//   busy         - high in every state except IDLE
//   done         - one-cycle pulse on successful commit
//   div_zero_exc - one-cycle pulse when a division is refused
//   cycle_cnt    - remaining run cycles
//
// Optional feature: define MULDIV_ABORT_EN to add the abort input.
// All outputs are registered and updated in one state-machine block.

module muldiv_sequencer #(
   parameter int MULT_CYCLES = 32,
   parameter int DIV_CYCLES  = 32,
   parameter int CNT_W       = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic             div_zero,
`ifdef MULDIV_ABORT_EN
   input  logic             abort,
`endif
   output logic             mult_ctrl,
   output logic             div_ctrl,
   output logic             src_hilo,
   output logic             hilo_write,
   output logic             busy,
   output logic             done,
   output logic             div_zero_exc,
   output logic [CNT_W-1:0] cycle_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      RUN_MULT,
      RUN_DIV,
      COMMIT,
      EXC
   } stateT;

   localparam logic [CNT_W-1:0] multLoad = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] divLoad  = CNT_W'(DIV_CYCLES - 1);

   stateT state;
   logic  abortReq;

`ifdef MULDIV_ABORT_EN
   assign abortReq = abort;
`else
   assign abortReq = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         mult_ctrl    <= 1'b0;
         div_ctrl     <= 1'b0;
         src_hilo     <= 1'b0;
         hilo_write   <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         div_zero_exc <= 1'b0;
         cycle_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               mult_ctrl    <= 1'b0;
               div_ctrl     <= 1'b0;
               hilo_write   <= 1'b0;
               done         <= 1'b0;
               div_zero_exc <= 1'b0;
               busy         <= 1'b0;
               cycle_cnt    <= '0;
               if (start) begin
                  busy <= 1'b1;
                  if (!op) begin
                     state     <= RUN_MULT;
                     mult_ctrl <= 1'b1;
                     src_hilo  <= 1'b0;
                     cycle_cnt <= multLoad;
                  end else if (div_zero) begin
                     state        <= EXC;
                     div_zero_exc <= 1'b1;
                     src_hilo     <= 1'b1;
                  end else begin
                     state     <= RUN_DIV;
                     div_ctrl  <= 1'b1;
                     src_hilo  <= 1'b1;
                     cycle_cnt <= divLoad;
                  end
               end
            end

            RUN_MULT, RUN_DIV: begin
               if (abortReq) begin
                  // Cancelled run: return straight to IDLE without a commit.
                  state     <= IDLE;
                  mult_ctrl <= 1'b0;
                  div_ctrl  <= 1'b0;
                  busy      <= 1'b0;
                  cycle_cnt <= '0;
               end else if (cycle_cnt == '0) begin
                  state      <= COMMIT;
                  mult_ctrl  <= 1'b0;
                  div_ctrl   <= 1'b0;
                  hilo_write <= 1'b1;
                  done       <= 1'b1;
               end else begin
                  cycle_cnt <= cycle_cnt - 1'b1;
               end
            end

            COMMIT: begin
               state      <= IDLE;
               hilo_write <= 1'b0;
               done       <= 1'b0;
               busy       <= 1'b0;
            end

            EXC: begin
               state        <= IDLE;
               div_zero_exc <= 1'b0;
               busy         <= 1'b0;
            end

            default: begin
               state        <= IDLE;
               mult_ctrl    <= 1'b0;
               div_ctrl     <= 1'b0;
               hilo_write   <= 1'b0;
               done         <= 1'b0;
               div_zero_exc <= 1'b0;
               busy         <= 1'b0;
               cycle_cnt    <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Directed bench for muldiv_sequencer with MULT_CYCLES = DIV_CYCLES = 32.
//   Expected values are hand-derived from the cycle timing of each operation.

module tb_muldiv_sequencer;

   localparam int MC = 32;
   localparam int DC = 32;
   localparam int CW = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          op;
   logic          div_zero;
`ifdef MULDIV_ABORT_EN
   logic          abort;
`endif
   logic          mult_ctrl;
   logic          div_ctrl;
   logic          src_hilo;
   logic          hilo_write;
   logic          busy;
   logic          done;
   logic          div_zero_exc;
   logic [CW-1:0] cycle_cnt;

   int assertCount = 0;
   int failCount   = 0;
   int hiloCount   = 0;
   int hiloBefore;

   muldiv_sequencer #(
      .MULT_CYCLES(MC),
      .DIV_CYCLES (DC),
      .CNT_W      (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .div_zero    (div_zero),
`ifdef MULDIV_ABORT_EN
      .abort       (abort),
`endif
      .mult_ctrl   (mult_ctrl),
      .div_ctrl    (div_ctrl),
      .src_hilo    (src_hilo),
      .hilo_write  (hilo_write),
      .busy        (busy),
      .done        (done),
      .div_zero_exc(div_zero_exc),
      .cycle_cnt   (cycle_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] actual,
                           input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count Hi/Lo writes and enforce mutual exclusion of the unit controls.
   always @(negedge clk) begin
      if (hilo_write === 1'b1) hiloCount++;
      checkVal("exclusive",
               32'($countones({mult_ctrl, div_ctrl, hilo_write, div_zero_exc})), 
               32'($countones({mult_ctrl, div_ctrl, hilo_write, div_zero_exc}) > 1 ? 0 :
                   $countones({mult_ctrl, div_ctrl, hilo_write, div_zero_exc})));
   end

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      op       = 1'b0;
      div_zero = 1'b0;
`ifdef MULDIV_ABORT_EN
      abort    = 1'b0;
`endif
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      checkVal("rst_busy", 32'(busy), 0);
      checkVal("rst_mult", 32'(mult_ctrl), 0);
      checkVal("rst_div", 32'(div_ctrl), 0);
      checkVal("rst_src", 32'(src_hilo), 0);
      checkVal("rst_hilo", 32'(hilo_write), 0);
      checkVal("rst_done", 32'(done), 0);
      checkVal("rst_exc", 32'(div_zero_exc), 0);
      checkVal("rst_cnt", 32'(cycle_cnt), 0);

      // 1: multiplication, full length
      start = 1'b1; op = 1'b0;
      tick();
      start = 1'b0;
      for (int i = 0; i < MC; i++) begin
         checkVal("m_ctrl", 32'(mult_ctrl), 1);
         checkVal("m_cnt", 32'(cycle_cnt), 32'(MC - 1 - i));
         checkVal("m_busy", 32'(busy), 1);
         checkVal("m_hilo", 32'(hilo_write), 0);
         tick();
      end
      checkVal("m_c_hilo", 32'(hilo_write), 1);
      checkVal("m_c_done", 32'(done), 1);
      checkVal("m_c_src", 32'(src_hilo), 0);
      checkVal("m_c_ctrl", 32'(mult_ctrl), 0);
      checkVal("m_c_cnt", 32'(cycle_cnt), 0);
      tick();
      checkVal("m_i_busy", 32'(busy), 0);
      checkVal("m_i_done", 32'(done), 0);
      checkVal("m_i_hilo", 32'(hilo_write), 0);

      // 2: division, full length
      start = 1'b1; op = 1'b1; div_zero = 1'b0;
      tick();
      start = 1'b0;
      for (int i = 0; i < DC; i++) begin
         checkVal("d_ctrl", 32'(div_ctrl), 1);
         checkVal("d_mult", 32'(mult_ctrl), 0);
         checkVal("d_cnt", 32'(cycle_cnt), 32'(DC - 1 - i));
         tick();
      end
      checkVal("d_c_hilo", 32'(hilo_write), 1);
      checkVal("d_c_done", 32'(done), 1);
      checkVal("d_c_src", 32'(src_hilo), 1);
      checkVal("d_c_ctrl", 32'(div_ctrl), 0);
      tick();
      checkVal("d_i_busy", 32'(busy), 0);
      checkVal("d_i_src", 32'(src_hilo), 1);

      // 3: divide by zero refused
      start = 1'b1; op = 1'b1; div_zero = 1'b1;
      tick();
      start = 1'b0; div_zero = 1'b0;
      checkVal("z_exc", 32'(div_zero_exc), 1);
      checkVal("z_busy", 32'(busy), 1);
      checkVal("z_div", 32'(div_ctrl), 0);
      checkVal("z_hilo", 32'(hilo_write), 0);
      checkVal("z_done", 32'(done), 0);
      checkVal("z_cnt", 32'(cycle_cnt), 0);
      checkVal("z_src", 32'(src_hilo), 1);
      tick();
      checkVal("z_i_exc", 32'(div_zero_exc), 0);
      checkVal("z_i_busy", 32'(busy), 0);
      checkVal("z_i_div", 32'(div_ctrl), 0);

      // 4: start held high, accepted once per 34 cycles
      start = 1'b1; op = 1'b0;
      tick();
      for (int rep = 0; rep < 2; rep++) begin
         checkVal("h_cnt", 32'(cycle_cnt), 31);
         checkVal("h_ctrl", 32'(mult_ctrl), 1);
         repeat (MC) tick();
         checkVal("h_c_done", 32'(done), 1);
         checkVal("h_c_busy", 32'(busy), 1);
         tick();
         checkVal("h_i_busy", 32'(busy), 0);
         checkVal("h_i_ctrl", 32'(mult_ctrl), 0);
         tick();
      end
      start = 1'b0;
      checkVal("h_cnt3", 32'(cycle_cnt), 31);
      repeat (MC) tick();
      checkVal("h_c3_done", 32'(done), 1);
      tick();
      checkVal("h_i3_busy", 32'(busy), 0);

      // 5: reset in the middle of a multiplication
      start = 1'b1; op = 1'b0;
      tick();
      start = 1'b0;
      repeat (9) tick();
      checkVal("r_cnt10", 32'(cycle_cnt), 22);
      checkVal("r_ctrl10", 32'(mult_ctrl), 1);
      hiloBefore = hiloCount;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkVal("r_mult", 32'(mult_ctrl), 0);
      checkVal("r_busy", 32'(busy), 0);
      checkVal("r_cnt", 32'(cycle_cnt), 0);
      checkVal("r_src", 32'(src_hilo), 0);
      checkVal("r_hilo", 32'(hilo_write), 0);
      checkVal("r_done", 32'(done), 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      checkVal("r_new_ctrl", 32'(mult_ctrl), 1);
      checkVal("r_new_cnt", 32'(cycle_cnt), 31);
      checkVal("r_no_write", 32'(hiloCount), 32'(hiloBefore));
      repeat (MC) tick();
      checkVal("r_c_hilo", 32'(hilo_write), 1);
      tick();

`ifdef MULDIV_ABORT_EN
      // 6: abort in the middle of a division
      start = 1'b1; op = 1'b1; div_zero = 1'b0;
      tick();
      start = 1'b0;
      repeat (4) tick();
      checkVal("a_cnt5", 32'(cycle_cnt), 27);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkVal("a_busy", 32'(busy), 0);
      checkVal("a_div", 32'(div_ctrl), 0);
      checkVal("a_done", 32'(done), 0);
      checkVal("a_hilo", 32'(hilo_write), 0);
      checkVal("a_cnt", 32'(cycle_cnt), 0);
      start = 1'b1; op = 1'b0;
      tick();
      start = 1'b0;
      repeat (MC) tick();
      checkVal("a_m_done", 32'(done), 1);
      checkVal("a_m_src", 32'(src_hilo), 0);
      tick();
      checkVal("a_m_busy", 32'(busy), 0);
`endif

      tick();
      tick();
`ifdef MULDIV_ABORT_EN
      checkVal("hilo_total", 32'(hiloCount), 7);
`else
      checkVal("hilo_total", 32'(hiloCount), 6);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               assertCount, failCount);
      $finish;
   end

endmodule
